scoreboard_rx: RTL and testbench

Receiving end of the scoreboard word stream. Consumes 32-bit `{userid, score}` words qualified by a toggling parity bit, and keeps a sorted top-N leaderboard for the display logic. Frame boundaries come from `game_state` and a terminator word. Sits between the RAM-side scoreboard reader and the seven-segment/VGA scoreboard display.

---
 rtl/scoreboard_pkg.sv | 19 +
 rtl/leaderboard_table.sv | 85 ++++++++
 rtl/scoreboard_rx.sv | 134 +++++++++++++
 tb/tb_scoreboard_rx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the scoreboard receive path.
package scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam int USERID_MSB = 31;
    localparam int USERID_LSB = 16;
    localparam int SCORE_MSB  = 15;

    localparam logic [15:0] TERMINATOR_ID = 16'hFFFF;

    localparam logic [1:0] GS_REQ  = 2'b01;
    localparam logic [1:0] GS_IDLE = 2'b00;

endpackage

// File: rtl/leaderboard_table.sv
// Sorted top-N table: clear, insert-with-shift and the rank readout mux.
module leaderboard_table #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 insert,
    input  logic [15:0]          ins_userid,
    input  logic [15:0]          ins_score,
    input  logic [$clog2(N)-1:0] rank_sel,
    output logic [15:0]          rank_userid,
    output logic [15:0]          rank_score,
    output logic                 rank_valid
);

    logic [15:0] uid_q   [N];
    logic [15:0] score_q [N];
    logic [N-1:0] valid_q;

    logic [N-1:0] lower;
    logic [N-1:0] prev_lower;
    logic [N-1:0] prev_valid;
    logic [15:0]  prev_uid   [N];
    logic [15:0]  prev_score [N];
    logic         sel_ok;

    // The table stays sorted with valid entries packed at the top, so "lower"
    // is monotonic: the first set bit is the insertion slot, later set bits shift.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            lower[i] = !valid_q[i] || (score_q[i] < ins_score);
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_prev
        if (g == 0) begin : g_first
            assign prev_lower[g] = 1'b0;
            assign prev_valid[g] = 1'b0;
            assign prev_uid[g]   = '0;
            assign prev_score[g] = '0;
        end else begin : g_rest
            assign prev_lower[g] = lower[g-1];
            assign prev_valid[g] = valid_q[g-1];
            assign prev_uid[g]   = uid_q[g-1];
            assign prev_score[g] = score_q[g-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                uid_q[i]   <= '0;
                score_q[i] <= '0;
            end
            valid_q <= '0;
        end else if (clear) begin
            for (int i = 0; i < N; i++) begin
                uid_q[i]   <= '0;
                score_q[i] <= '0;
            end
            valid_q <= '0;
        end else if (insert) begin
            for (int i = 0; i < N; i++) begin
                if (lower[i]) begin
                    if (prev_lower[i]) begin
                        uid_q[i]   <= prev_uid[i];
                        score_q[i] <= prev_score[i];
                        valid_q[i] <= prev_valid[i];
                    end else begin
                        uid_q[i]   <= ins_userid;
                        score_q[i] <= ins_score;
                        valid_q[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign sel_ok      = int'(rank_sel) < N;
    assign rank_userid = sel_ok ? uid_q[rank_sel]   : '0;
    assign rank_score  = sel_ok ? score_q[rank_sel] : '0;
    assign rank_valid  = sel_ok ? valid_q[rank_sel] : 1'b0;

endmodule

// File: rtl/scoreboard_rx.sv
// Receives parity-qualified {userid, score} words and maintains the top-N leaderboard.
module scoreboard_rx
    import scoreboard_pkg::*;
#(
    parameter int N         = 4,
    parameter int MAX_WORDS = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           game_state,
    input  logic [31:0]          scoreboard_output,
    input  logic                 scoreboard_parity,
    input  logic [$clog2(N)-1:0] rank_sel,
    output logic [15:0]          rank_userid,
    output logic [15:0]          rank_score,
    output logic                 rank_valid,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 overflow,
    output logic [15:0]          word_count
);

    localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

    state_t      state;
    logic        par_q;
    logic [1:0]  gs_prev;
    logic [31:0] word_q;
    logic        word_v;

    logic        tog;
    logic        start;
    logic        abort;
    logic        is_term;
    logic        in_collect;
    logic        accept;
    logic        term_hit;
    logic        max_hit;
    logic        insert;
    logic        clear;
    logic [15:0] count_inc;

    assign tog        = scoreboard_parity ^ par_q;
    assign start      = (game_state == GS_REQ) && (gs_prev != GS_REQ);
    assign abort      = (game_state == GS_IDLE);
    assign is_term    = (word_q[USERID_MSB:USERID_LSB] == TERMINATOR_ID);
    assign in_collect = (state == ST_COLLECT) && !abort;
    assign accept     = in_collect && word_v && !is_term;
    assign term_hit   = in_collect && word_v && is_term;
    assign count_inc  = (word_count < MAX_W) ? word_count + 16'd1 : word_count;
    assign max_hit    = accept && (count_inc == MAX_W);
    assign insert     = accept && (word_q[SCORE_MSB:0] != 16'd0);
    assign clear      = (state == ST_IDLE) && start;

    // Stage 1 captures on a parity toggle; stage 2 (word_v) counts, inserts
    // and decides whether the frame ends, so back-to-back words never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            par_q      <= 1'b0;
            gs_prev    <= GS_IDLE;
            word_q     <= '0;
            word_v     <= 1'b0;
            word_count <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            par_q      <= scoreboard_parity;
            gs_prev    <= game_state;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    word_v <= 1'b0;
                    if (start) begin
                        state      <= ST_COLLECT;
                        busy       <= 1'b1;
                        word_count <= '0;
                        overflow   <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (abort) begin
                        state  <= ST_IDLE;
                        busy   <= 1'b0;
                        word_v <= 1'b0;
                    end else begin
                        if (accept) begin
                            word_count <= count_inc;
                        end
                        if (term_hit || max_hit) begin
                            state      <= ST_DONE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            word_v     <= 1'b0;
                            if (max_hit) begin
                                overflow <= 1'b1;
                            end
                        end else begin
                            word_v <= tog;
                            if (tog) begin
                                word_q <= scoreboard_output;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    word_v <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    word_v <= 1'b0;
                end
            endcase
        end
    end

    leaderboard_table #(
        .N(N)
    ) u_table (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .insert      (insert),
        .ins_userid  (word_q[USERID_MSB:USERID_LSB]),
        .ins_score   (word_q[SCORE_MSB:0]),
        .rank_sel    (rank_sel),
        .rank_userid (rank_userid),
        .rank_score  (rank_score),
        .rank_valid  (rank_valid)
    );

endmodule

// File: tb/tb_scoreboard_rx.sv
// Directed plus randomized bench for scoreboard_rx against a stable-sort leaderboard model.
module tb_scoreboard_rx;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  game_state;
    logic [31:0] scoreboard_output;
    logic        scoreboard_parity;
    logic [1:0]  rank_sel;

    logic [15:0] rank_userid, rank_score, word_count;
    logic        rank_valid, busy, frame_done, overflow;
    logic [15:0] ov_rank_userid, ov_rank_score, ov_word_count;
    logic        ov_rank_valid, ov_busy, ov_frame_done, ov_overflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] uid;
        logic [15:0] score;
    } ent_t;

    ent_t model_q[$];
    int   model_count;

    always #5 clk = ~clk;

    scoreboard_rx #(.N(N), .MAX_WORDS(1024)) dut (
        .clk               (clk),
        .rst               (rst),
        .game_state        (game_state),
        .scoreboard_output (scoreboard_output),
        .scoreboard_parity (scoreboard_parity),
        .rank_sel          (rank_sel),
        .rank_userid       (rank_userid),
        .rank_score        (rank_score),
        .rank_valid        (rank_valid),
        .busy              (busy),
        .frame_done        (frame_done),
        .overflow          (overflow),
        .word_count        (word_count)
    );

    scoreboard_rx #(.N(N), .MAX_WORDS(4)) dut_ov (
        .clk               (clk),
        .rst               (rst),
        .game_state        (game_state),
        .scoreboard_output (scoreboard_output),
        .scoreboard_parity (scoreboard_parity),
        .rank_sel          (rank_sel),
        .rank_userid       (ov_rank_userid),
        .rank_score        (ov_rank_score),
        .rank_valid        (ov_rank_valid),
        .busy              (ov_busy),
        .frame_done        (ov_frame_done),
        .overflow          (ov_overflow),
        .word_count        (ov_word_count)
    );

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_word(input logic [31:0] data);
        @(negedge clk);
        scoreboard_output = data;
        scoreboard_parity = ~scoreboard_parity;
    endtask

    task automatic apply_stimulus(input logic [15:0] uid, input logic [15:0] score, input int gap);
        ent_t e;
        drive_word({uid, score});
        e.uid   = uid;
        e.score = score;
        if (score != 16'd0) model_q.push_back(e);
        model_count++;
        repeat (gap) @(negedge clk);
    endtask

    task automatic start_frame();
        @(negedge clk);
        game_state = 2'b00;
        @(negedge clk);
        game_state = 2'b01;
        @(negedge clk);
        model_q.delete();
        model_count = 0;
        check_output("busy_start", 32'(busy), 32'd1);
    endtask

    task automatic end_frame(input string tag);
        drive_word(32'hFFFF_0000);
        @(negedge clk);
        check_output({tag, "_fd_early"}, 32'(frame_done), 32'd0);
        @(negedge clk);
        check_output({tag, "_fd_pulse"}, 32'(frame_done), 32'd1);
        check_output({tag, "_busy_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check_output({tag, "_fd_end"}, 32'(frame_done), 32'd0);
        check_output({tag, "_count"}, 32'(word_count), 32'(model_count));
    endtask

    // Expected rank r is the r-th pick of a stable descending sort of all ranked words.
    task automatic check_output_table(input string tag, input bit use_ov);
        bit taken[];
        int best;
        logic        v;
        logic [15:0] u, s;
        taken = new[model_q.size()];
        for (int r = 0; r < N; r++) begin
            best = -1;
            for (int i = 0; i < model_q.size(); i++) begin
                if (!taken[i] && (best < 0 || model_q[i].score > model_q[best].score)) best = i;
            end
            rank_sel = 2'(r);
            #1;
            v = use_ov ? ov_rank_valid  : rank_valid;
            u = use_ov ? ov_rank_userid : rank_userid;
            s = use_ov ? ov_rank_score  : rank_score;
            if (best < 0) begin
                check_output($sformatf("%s_r%0d_valid", tag, r), 32'(v), 32'd0);
            end else begin
                taken[best] = 1'b1;
                check_output($sformatf("%s_r%0d_valid", tag, r), 32'(v), 32'd1);
                check_output($sformatf("%s_r%0d_uid", tag, r), 32'(u), 32'(model_q[best].uid));
                check_output($sformatf("%s_r%0d_score", tag, r), 32'(s), 32'(model_q[best].score));
            end
        end
    endtask

    initial begin
        ent_t e;
        int nw;
        logic [15:0] sc;

        rst               = 1'b1;
        game_state        = 2'b00;
        scoreboard_output = '0;
        scoreboard_parity = 1'b0;
        rank_sel          = '0;
        model_count       = 0;
        repeat (2) @(negedge clk);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_fd", 32'(frame_done), 32'd0);
        check_output("rst_ovf", 32'(overflow), 32'd0);
        check_output("rst_count", 32'(word_count), 32'd0);
        check_output("rst_valid", 32'(rank_valid), 32'd0);
        check_output("rst_uid", 32'(rank_userid), 32'd0);
        check_output("rst_score", 32'(rank_score), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_output_table("post_rst", 1'b0);

        $display("[TB] basic frame");
        start_frame();
        apply_stimulus(16'h0001, 16'd50, 0);
        @(negedge clk);
        check_output("lat_k", 32'(word_count), 32'd0);
        @(negedge clk);
        check_output("lat_k1", 32'(word_count), 32'd1);
        apply_stimulus(16'h0002, 16'd90, 1);
        apply_stimulus(16'h0003, 16'd70, 1);
        end_frame("basic");
        check_output_table("basic", 1'b0);
        rank_sel = 2'd0;
        #1;
        check_output("basic_top_uid", 32'(rank_userid), 32'h0002);

        $display("[TB] ties and drops");
        start_frame();
        apply_stimulus(16'h0011, 16'd10, 1);
        apply_stimulus(16'h0012, 16'd60, 1);
        apply_stimulus(16'h0013, 16'd30, 1);
        apply_stimulus(16'h0014, 16'd60, 1);
        apply_stimulus(16'h0015, 16'd80, 1);
        apply_stimulus(16'h0016, 16'd5, 1);
        end_frame("ties");
        check_output_table("ties", 1'b0);
        rank_sel = 2'd1;
        #1;
        check_output("ties_r1_first", 32'(rank_userid), 32'h0012);

        $display("[TB] back-to-back");
        start_frame();
        apply_stimulus(16'h0101, 16'd7, 0);
        apply_stimulus(16'h0102, 16'd9, 0);
        apply_stimulus(16'h0103, 16'd8, 0);
        end_frame("b2b");
        check_output_table("b2b", 1'b0);

        $display("[TB] zero score and idle toggles");
        start_frame();
        apply_stimulus(16'h0021, 16'd0, 1);
        apply_stimulus(16'h0022, 16'd40, 1);
        end_frame("zero");
        check_output_table("zero", 1'b0);
        drive_word({16'h0023, 16'd99});
        drive_word({16'h0024, 16'd98});
        @(negedge clk);
        drive_word({16'h0025, 16'd97});
        repeat (3) @(negedge clk);
        check_output("idle_count", 32'(word_count), 32'd2);
        check_output_table("idle", 1'b0);

        $display("[TB] abort");
        start_frame();
        apply_stimulus(16'h0031, 16'd25, 1);
        apply_stimulus(16'h0032, 16'd35, 2);
        game_state = 2'b00;
        @(negedge clk);
        check_output("abort_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_output($sformatf("abort_fd%0d", i), 32'(frame_done), 32'd0);
            @(negedge clk);
        end
        check_output("abort_count", 32'(word_count), 32'd2);
        check_output_table("abort_kept", 1'b0);
        start_frame();
        check_output("restart_count", 32'(word_count), 32'd0);
        check_output_table("restart_clr", 1'b0);

        $display("[TB] overflow and async reset");
        start_frame();
        apply_stimulus(16'h0041, 16'd5, 2);
        apply_stimulus(16'h0042, 16'd9, 2);
        apply_stimulus(16'h0043, 16'd7, 2);
        apply_stimulus(16'h0044, 16'd9, 2);
        check_output("ov_busy", 32'(ov_busy), 32'd0);
        check_output("ov_flag", 32'(ov_overflow), 32'd1);
        apply_stimulus(16'h0045, 16'd100, 3);
        check_output("ov_count", 32'(ov_word_count), 32'd4);
        check_output("main_count5", 32'(word_count), 32'(model_count));
        check_output("main_busy5", 32'(busy), 32'd1);
        check_output("main_ovf", 32'(overflow), 32'd0);
        e = model_q.pop_back();
        check_output_table("ov_tab", 1'b1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_output("arst_busy", 32'(busy), 32'd0);
        check_output("arst_count", 32'(word_count), 32'd0);
        check_output("arst_valid", 32'(rank_valid), 32'd0);
        check_output("arst_ov_flag", 32'(ov_overflow), 32'd0);
        check_output("arst_ov_count", 32'(ov_word_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        model_count = 0;
        check_output_table("arst_tab", 1'b0);

        $display("[TB] random frames");
        for (int f = 0; f < 6; f++) begin
            start_frame();
            nw = $urandom_range(1, 12);
            for (int w = 0; w < nw; w++) begin
                if ($urandom_range(0, 3) == 0) sc = 16'($urandom_range(0, 3));
                else sc = 16'($urandom_range(0, 40));
                apply_stimulus(16'($urandom_range(0, 16'hFFFE)), sc, $urandom_range(0, 2));
            end
            end_frame($sformatf("rnd%0d", f));
            check_output_table($sformatf("rnd%0d", f), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
